// File: rtl/lfsr_sequencer_if.sv
// Bus bundle for lfsr_sequencer: table inputs, advance strobe and chip outputs.
// The sequencer takes the slave modport; the producer/consumer side takes master.
interface lfsr_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             ena_i;
  logic [4:0]       degree_i;
  logic [WIDTH-1:0] mask_i;
  logic [WIDTH-1:0] len_i;
  logic             strobe_i;
  logic             pn_o;
  logic             valid_o;
  logic             sync_o;
  logic [WIDTH-1:0] index_o;
  logic             err_o;

  modport slave (
    input  ena_i, degree_i, mask_i, len_i, strobe_i,
    output pn_o, valid_o, sync_o, index_o, err_o
  );

  modport master (
    output ena_i, degree_i, mask_i, len_i, strobe_i,
    input  pn_o, valid_o, sync_o, index_o, err_o
  );
endinterface

// File: rtl/lfsr_sequencer.sv
// PN-sequence generator: right-shifting Galois LFSR fed by the constant table.
// Emits one chip per strobe in RUN, with a period-start marker and chip index.
// Optional feature macro: LFSR_SEQ_PERIOD_CHECK_EN -- when defined, the register
// value after each period wrap is compared with SEED and a sticky err_o is raised
// on mismatch; when undefined no comparator exists and err_o is tied low.
module lfsr_sequencer #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  lfsr_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [4:0]       deg_q, deg_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             pn_q, pn_d;
  logic             valid_q, valid_d;
  logic             sync_q, sync_d;
  logic [WIDTH-1:0] idx_q, idx_d;

  logic             deg_ok;
  logic             wrap;
  logic [WIDTH-1:0] r_step;

  // Only degrees the table actually covers may start or keep a run
  assign deg_ok = (bus.degree_i >= 5'd2) && (bus.degree_i <= 5'd16);
  // Last chip of the period; len 16'hFFFF wraps at 16'hFFFE so no overflow
  assign wrap   = (cnt_q == len_q - WIDTH'(1));
  // Galois step: shift right, fold the mask in when a one falls out
  assign r_step = r_q[0] ? ((r_q >> 1) ^ mask_q) : (r_q >> 1);

`ifdef LFSR_SEQ_PERIOD_CHECK_EN
  logic err_q, err_d;
`endif

  // Next-state: FSM, table latch, LFSR step and chip outputs
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    deg_d   = deg_q;
    mask_d  = mask_q;
    len_d   = len_q;
    pn_d    = pn_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    sync_d  = 1'b0;
`ifdef LFSR_SEQ_PERIOD_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.ena_i && deg_ok) state_d = S_LOAD;
      end
      S_LOAD: begin
        // strobe is ignored here; the table values are captured once per run
        deg_d   = bus.degree_i;
        mask_d  = bus.mask_i;
        len_d   = bus.len_i;
        r_d     = SEED;
        cnt_d   = '0;
        state_d = S_RUN;
`ifdef LFSR_SEQ_PERIOD_CHECK_EN
        err_d   = 1'b0;
`endif
      end
      S_RUN: begin
        // exits win over a strobe in the same cycle
        if (!bus.ena_i || !deg_ok) begin
          state_d = S_IDLE;
        end else if (bus.degree_i != deg_q) begin
          state_d = S_LOAD;
        end else if (bus.strobe_i) begin
          pn_d    = r_q[0];
          idx_d   = cnt_q;
          sync_d  = (cnt_q == '0);
          valid_d = 1'b1;
          r_d     = r_step;
          cnt_d   = wrap ? '0 : cnt_q + WIDTH'(1);
`ifdef LFSR_SEQ_PERIOD_CHECK_EN
          // a correct mask/len pair returns to SEED exactly at the wrap
          if (wrap && (r_step != SEED)) err_d = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      r_q     <= SEED;
      cnt_q   <= '0;
      deg_q   <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      pn_q    <= 1'b0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      deg_q   <= deg_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      pn_q    <= pn_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      idx_q   <= idx_d;
    end
  end

`ifdef LFSR_SEQ_PERIOD_CHECK_EN
  // Sticky period-mismatch flag, cleared by reset or LOAD
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.pn_o    = pn_q;
  assign bus.valid_o = valid_q;
  assign bus.sync_o  = sync_q;
  assign bus.index_o = idx_q;

endmodule
